intc_vec: RTL and testbench

- Parametrised vectored interrupt controller for the monocycle CPU.
- Replaces the fixed 8-line combinational interrupt-to-vector mapping in the control unit.
- Adds per-line enables, edge/level modes, pending latches, fixed priority, and in-service tracking for nested interrupts.
- Handshakes with the control unit: req/ack on entry (PC push), eoi on return (PC pop).

---
 rtl/intc_pkg.sv | 14 +
 rtl/prio_enc_lsb.sv | 23 ++
 rtl/intc_vec.sv | 128 ++++++++++++
 tb/tb_intc_vec.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared types and vector arithmetic for the vectored interrupt controller
package intc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } intc_state_e;

    // Wide result; the caller truncates to its vector width, so wrap-around is intended.
    function automatic int vec_of(input int idx, input int base, input int stride);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// rtl/prio_enc_lsb.sv - lowest-set-bit priority encoder
module prio_enc_lsb #(
    parameter int N = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intc_vec.sv
// rtl/intc_vec.sv - vectored interrupt controller with enables, edge/level modes and nesting
module intc_vec
    import intc_pkg::*;
#(
    parameter int N_IRQ      = 8,
    parameter int VEC_W      = 8,
    parameter int VEC_BASE   = 0,
    parameter int VEC_STRIDE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] edge_mode,
    input  logic             en_we,
    input  logic [N_IRQ-1:0] en_wdata,
    output logic [N_IRQ-1:0] irq_en,
    output logic             irq_req,
    output logic [VEC_W-1:0] irq_vec,
    input  logic             irq_ack,
    input  logic             irq_eoi,
    output logic [N_IRQ-1:0] in_service,
    output logic             spurious_eoi
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic [N_IRQ-1:0] s, s_d, rise;
    logic [N_IRQ-1:0] pending, pending_n;
    logic [N_IRQ-1:0] in_service_n;
    logic [N_IRQ-1:0] thresh, elig;
    logic [IW-1:0]    win, wl, wl_n, is_idx;
    logic             win_valid, is_valid;
    logic             ack_fire;
    logic [VEC_W-1:0] vec_n;
    intc_state_e      state, state_n;

    assign rise    = s & ~s_d;
    assign irq_req = (state == REQ);

    // Lowest in-service line sets the preemption ceiling and is the one eoi retires.
    prio_enc_lsb #(.N(N_IRQ)) u_is_enc (
        .vec   (in_service),
        .idx   (is_idx),
        .valid (is_valid)
    );

    always_comb begin
        thresh = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            thresh[i] = !is_valid || (i < int'(is_idx));
        end
    end

    assign elig = pending & irq_en & thresh;

    prio_enc_lsb #(.N(N_IRQ)) u_win_enc (
        .vec   (elig),
        .idx   (win),
        .valid (win_valid)
    );

    always_comb begin
        state_n  = state;
        vec_n    = irq_vec;
        wl_n     = wl;
        ack_fire = 1'b0;
        case (state)
            IDLE: begin
                if (win_valid) begin
                    state_n = REQ;
                    vec_n   = VEC_W'(vec_of(int'(win), VEC_BASE, VEC_STRIDE));
                    wl_n    = win;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    ack_fire = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // A new edge in the ack cycle must not be lost, so the set is applied after the clear.
    always_comb begin
        pending_n = pending;
        for (int i = 0; i < N_IRQ; i++) begin
            if (edge_mode[i]) begin
                if (ack_fire && (wl == IW'(i))) pending_n[i] = 1'b0;
                if (rise[i]) pending_n[i] = 1'b1;
            end else begin
                pending_n[i] = s[i];
            end
        end
    end

    always_comb begin
        in_service_n = in_service;
        if (irq_eoi && is_valid) in_service_n[is_idx] = 1'b0;
        if (ack_fire) in_service_n[wl] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            s            <= '0;
            s_d          <= '0;
            pending      <= '0;
            in_service   <= '0;
            irq_en       <= '0;
            irq_vec      <= '0;
            wl           <= '0;
            spurious_eoi <= 1'b0;
        end else begin
            state        <= state_n;
            s            <= irq_in;
            s_d          <= s;
            pending      <= pending_n;
            in_service   <= in_service_n;
            irq_vec      <= vec_n;
            wl           <= wl_n;
            spurious_eoi <= irq_eoi && !is_valid;
            if (en_we) irq_en <= en_wdata;
        end
    end

endmodule

// File: tb/tb_intc_vec.sv
// tb/tb_intc_vec.sv - directed self-checking bench for intc_vec against a behavioural model
module tb_intc_vec;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq_in = '0;
    logic [7:0] edge_mode = 8'hFF;
    logic       en_we = 1'b0;
    logic [7:0] en_wdata = '0;
    logic       irq_ack = 1'b0;
    logic       irq_eoi = 1'b0;

    logic [7:0] irq_en, in_service, irq_vec;
    logic       irq_req, spurious_eoi;
    logic [7:0] irq_en2, in_service2, irq_vec2;
    logic       irq_req2, spurious_eoi2;

    int n_vec = 0;
    int n_miss = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    intc_vec u_dut (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .edge_mode    (edge_mode),
        .en_we        (en_we),
        .en_wdata     (en_wdata),
        .irq_en       (irq_en),
        .irq_req      (irq_req),
        .irq_vec      (irq_vec),
        .irq_ack      (irq_ack),
        .irq_eoi      (irq_eoi),
        .in_service   (in_service),
        .spurious_eoi (spurious_eoi)
    );

    intc_vec #(.VEC_BASE(32'h20), .VEC_STRIDE(4)) u_dut2 (
        .clk          (clk),
        .reset        (reset),
        .irq_in       (irq_in),
        .edge_mode    (edge_mode),
        .en_we        (en_we),
        .en_wdata     (en_wdata),
        .irq_en       (irq_en2),
        .irq_req      (irq_req2),
        .irq_vec      (irq_vec2),
        .irq_ack      (irq_ack),
        .irq_eoi      (irq_eoi),
        .in_service   (in_service2),
        .spurious_eoi (spurious_eoi2)
    );

    // Behavioural model: plain bit arrays and integer indices.
    bit [7:0] m_s, m_sd, m_pend, m_en, m_is;
    bit       m_req, m_sp;
    int       m_line;

    always @(posedge clk) begin : model
        int low, win;
        bit took;
        bit [7:0] np, nis;
        if (reset) begin
            m_s = '0; m_sd = '0; m_pend = '0; m_en = '0; m_is = '0;
            m_req = 1'b0; m_sp = 1'b0; m_line = 0;
        end else begin
            low = 8;
            for (int i = 7; i >= 0; i--) if (m_is[i]) low = i;
            win = -1;
            for (int i = 7; i >= 0; i--) if (i < low && m_pend[i] && m_en[i]) win = i;
            took = m_req && irq_ack;
            for (int i = 0; i < 8; i++)
                np[i] = edge_mode[i] ? ((m_pend[i] && !(took && m_line == i)) || (m_s[i] && !m_sd[i]))
                                     : m_s[i];
            nis = m_is;
            m_sp = 1'b0;
            if (irq_eoi) begin
                if (low < 8) nis[low] = 1'b0;
                else m_sp = 1'b1;
            end
            if (took) nis[m_line] = 1'b1;
            if (m_req) begin
                if (irq_ack) m_req = 1'b0;
            end else if (win >= 0) begin
                m_req  = 1'b1;
                m_line = win;
            end
            m_sd = m_s;
            m_s = irq_in;
            m_pend = np;
            m_is = nis;
            if (en_we) m_en = en_wdata;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("m_irq_req", 32'(irq_req), 32'(m_req));
            cmp("m_irq_en", 32'(irq_en), 32'(m_en));
            cmp("m_in_service", 32'(in_service), 32'(m_is));
            cmp("m_spurious", 32'(spurious_eoi), 32'(m_sp));
            cmp("m_irq_req2", 32'(irq_req2), 32'(m_req));
            if (m_req) begin
                cmp("m_irq_vec", 32'(irq_vec), 32'(8'(m_line)));
                cmp("m_irq_vec2", 32'(irq_vec2), 32'(8'(32'h20 + m_line * 4)));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] m);
        irq_in = m;
        cyc(1);
        irq_in = '0;
    endtask

    task automatic set_en(input logic [7:0] v);
        en_we = 1'b1;
        en_wdata = v;
        cyc(1);
        en_we = 1'b0;
    endtask

    task automatic ack1();
        irq_ack = 1'b1;
        cyc(1);
        irq_ack = 1'b0;
    endtask

    task automatic eoi1();
        irq_eoi = 1'b1;
        cyc(1);
        irq_eoi = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk_on = 1'b1;
        cmp("rst_req", 32'(irq_req), 32'h0);
        cmp("rst_is", 32'(in_service), 32'h0);
        cmp("rst_en", 32'(irq_en), 32'h0);
        reset = 1'b0;

        // single edge line 3
        set_en(8'h08);
        pulse(8'h08);
        cyc(1);
        cmp("edge_req_early", 32'(irq_req), 32'h0);
        cyc(1);
        cmp("edge_req", 32'(irq_req), 32'h1);
        cmp("edge_vec", 32'(irq_vec), 32'h03);
        cmp("edge_vec_scaled", 32'(irq_vec2), 32'h2C);
        cyc(2);
        cmp("edge_hold", 32'(irq_req), 32'h1);
        ack1();
        cmp("edge_ack_is", 32'(in_service), 32'h08);
        cmp("edge_ack_req", 32'(irq_req), 32'h0);
        eoi1();
        cyc(2);
        cmp("edge_no_rereq", 32'(irq_req), 32'h0);

        // spurious eoi
        eoi1();
        cmp("spur_pulse", 32'(spurious_eoi), 32'h1);
        cmp("spur_is", 32'(in_service), 32'h0);
        cyc(1);
        cmp("spur_clear", 32'(spurious_eoi), 32'h0);

        // simultaneous lines 1 and 5
        set_en(8'hFF);
        pulse(8'h22);
        cyc(2);
        cmp("sim_vec1", 32'(irq_vec), 32'h01);
        ack1();
        cmp("sim_is", 32'(in_service), 32'h02);
        cyc(3);
        cmp("sim_blocked", 32'(irq_req), 32'h0);
        eoi1();
        cyc(1);
        cmp("sim_req5", 32'(irq_req), 32'h1);
        cmp("sim_vec5", 32'(irq_vec), 32'h05);
        ack1();
        eoi1();

        // nesting: 4 in service, then 0 and 6
        pulse(8'h10);
        cyc(2);
        cmp("nest_vec4", 32'(irq_vec), 32'h04);
        ack1();
        pulse(8'h41);
        cyc(2);
        cmp("nest_req0", 32'(irq_req), 32'h1);
        cmp("nest_vec0", 32'(irq_vec), 32'h00);
        ack1();
        cmp("nest_is11", 32'(in_service), 32'h11);
        cyc(2);
        cmp("nest_no6a", 32'(irq_req), 32'h0);
        eoi1();
        cmp("nest_is10", 32'(in_service), 32'h10);
        cyc(2);
        cmp("nest_no6b", 32'(irq_req), 32'h0);
        eoi1();
        cmp("nest_is00", 32'(in_service), 32'h00);
        cyc(1);
        cmp("nest_vec6", 32'(irq_vec), 32'h06);
        ack1();
        eoi1();

        // level line 2
        edge_mode = 8'hFB;
        irq_in = 8'h04;
        cyc(3);
        cmp("lvl_req", 32'(irq_req), 32'h1);
        cmp("lvl_vec", 32'(irq_vec), 32'h02);
        ack1();
        eoi1();
        cyc(1);
        cmp("lvl_rereq", 32'(irq_req), 32'h1);
        ack1();
        irq_in = '0;
        cyc(2);
        eoi1();
        cyc(3);
        cmp("lvl_dropped", 32'(irq_req), 32'h0);
        edge_mode = 8'hFF;

        // masked pending line 7
        set_en(8'h7F);
        pulse(8'h80);
        cyc(3);
        cmp("mask_noreq", 32'(irq_req), 32'h0);
        set_en(8'hFF);
        cmp("mask_en_edge", 32'(irq_req), 32'h0);
        cyc(1);
        cmp("mask_req7", 32'(irq_req), 32'h1);
        cmp("mask_vec7", 32'(irq_vec), 32'h07);
        cmp("mask_vec7_scaled", 32'(irq_vec2), 32'h3C);
        ack1();
        eoi1();

        // reset while requesting line 2 with line 5 in service
        pulse(8'h20);
        cyc(2);
        ack1();
        pulse(8'h04);
        cyc(2);
        cmp("rreq_vec2", 32'(irq_vec), 32'h02);
        cmp("rreq_is", 32'(in_service), 32'h20);
        reset = 1'b1;
        cyc(1);
        cmp("rreq_req", 32'(irq_req), 32'h0);
        cmp("rreq_vec", 32'(irq_vec), 32'h0);
        cmp("rreq_en", 32'(irq_en), 32'h0);
        cmp("rreq_is0", 32'(in_service), 32'h0);
        reset = 1'b0;
        cyc(3);
        cmp("post_rst_req", 32'(irq_req), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
